// File: rtl/chime_pkg.sv
// chime_pkg: shared definitions for the LED chime/alarm scheduler.
//   - FSM state codes (3-bit, legacy-compatible constants)
//   - owner codes driven on chime_scheduler.src
//   - quiet-window bounds used when CHIME_QUIET_EN is defined
//   - helpers: hour -> flash count, state -> owner code
package chime_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CHIME_ON  = 3'd1;
    localparam logic [2:0] ST_CHIME_OFF = 3'd2;
    localparam logic [2:0] ST_ALARM_ON  = 3'd3;
    localparam logic [2:0] ST_ALARM_OFF = 3'd4;
    localparam logic [2:0] ST_SNOOZE    = 3'd5;

    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_CHIME  = 2'd1;
    localparam logic [1:0] SRC_ALARM  = 2'd2;
    localparam logic [1:0] SRC_SNOOZE = 2'd3;

    // Chime is silent for hours >= QUIET_START or < QUIET_END
    localparam logic [4:0] QUIET_START = 5'd22;
    localparam logic [4:0] QUIET_END   = 5'd7;

    // 12-hour dial position; midnight/noon flash 12 times
    function automatic logic [3:0] flash_count(input logic [4:0] hour_bin);
        logic [4:0] m;
        if (hour_bin >= 5'd24)      m = hour_bin - 5'd24;
        else if (hour_bin >= 5'd12) m = hour_bin - 5'd12;
        else                        m = hour_bin;
        if (m == 5'd0) return 4'd12;
        return 4'(m);
    endfunction

    function automatic logic [1:0] src_of(input logic [2:0] st);
        case (st)
            ST_CHIME_ON, ST_CHIME_OFF: return SRC_CHIME;
            ST_ALARM_ON, ST_ALARM_OFF: return SRC_ALARM;
            ST_SNOOZE:                 return SRC_SNOOZE;
            default:                   return SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/chime_scheduler_bcd2bin.sv
// bcd2bin: combinational two-digit BCD to 5-bit binary (valid for 00-31).
//   bcd in  8  two BCD digits
//   bin out 5  hi*10 + lo
module bcd2bin (
    input  logic [7:0] bcd,
    output logic [4:0] bin
);

    logic [4:0] hi;
    logic [4:0] lo;

    assign hi  = {1'b0, bcd[7:4]};
    assign lo  = {1'b0, bcd[3:0]};
    // hi*10 as hi*8 + hi*2
    assign bin = (hi << 3) + (hi << 1) + lo;

endmodule

// File: rtl/chime_scheduler.sv
// chime_scheduler: arbitrates the indicator LED between the hourly chime
// and the alarm (with snooze/stop).
// Optional feature macro: CHIME_QUIET_EN (chime suppressed 22:00-06:59).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   tick            2 Hz single-cycle enable, sets flash half-period
//   hour/minute/second       current time, BCD
//   alarm_hour/alarm_min     alarm time, BCD; alarm_en arms it
//   snooze, stop    single-cycle user pulses
//   light           LED drive (registered)
//   busy            state != IDLE (registered)
//   src             owner: 0 none, 1 chime, 2 alarm, 3 snooze (registered)
module chime_scheduler
    import chime_pkg::*;
#(
    parameter int unsigned ALARM_FLASHES = 60,
    parameter int unsigned SNOOZE_TICKS  = 600,
    parameter int unsigned MAX_SNOOZE    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic       light,
    output logic       busy,
    output logic [1:0] src
);

    localparam int unsigned PW = $clog2(ALARM_FLASHES + 1);
    localparam int unsigned TW = $clog2(SNOOZE_TICKS + 1);
    localparam int unsigned SW = $clog2(MAX_SNOOZE + 1);

    logic [4:0]    hour_bin;
    logic          chime_hit, alarm_hit, chime_hit_q, alarm_hit_q;
    logic          chime_rise, alarm_rise, quiet;
    logic          chime_pend, alarm_pend, chime_pend_n, alarm_pend_n;
    logic [2:0]    state, state_n;
    logic [3:0]    flash_cnt, flash_n;
    logic [PW-1:0] pair_cnt, pair_n;
    logic [TW-1:0] snz_ticks, ticks_n;
    logic [SW-1:0] snz_cnt, scnt_n;
    logic          resume_snz, resume_n;

    bcd2bin u_hour_bcd (
        .bcd (hour),
        .bin (hour_bin)
    );

`ifdef CHIME_QUIET_EN
    assign quiet = (hour_bin >= QUIET_START) || (hour_bin < QUIET_END);
`else
    assign quiet = 1'b0;
`endif

    assign chime_hit  = (minute == 8'h00) && (second == 8'h00);
    assign alarm_hit  = alarm_en && (hour == alarm_hour) && (minute == alarm_min)
                        && (second == 8'h00);
    assign chime_rise = chime_hit && !chime_hit_q && !quiet;
    assign alarm_rise = alarm_hit && !alarm_hit_q;

    always_comb begin
        state_n      = state;
        flash_n      = flash_cnt;
        pair_n       = pair_cnt;
        ticks_n      = snz_ticks;
        scnt_n       = snz_cnt;
        resume_n     = resume_snz;
        chime_pend_n = chime_pend;
        alarm_pend_n = alarm_pend;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    if (alarm_pend) begin
                        state_n      = ST_ALARM_ON;
                        alarm_pend_n = 1'b0;
                        chime_pend_n = 1'b0;
                        pair_n       = '0;
                    end else if (chime_pend) begin
                        state_n      = ST_CHIME_ON;
                        chime_pend_n = 1'b0;
                        flash_n      = flash_count(hour_bin);
                    end
                end
            end
            ST_CHIME_ON, ST_CHIME_OFF: begin
                if (tick) begin
                    if (alarm_pend) begin
                        // chime is abandoned, never resumed
                        state_n      = ST_ALARM_ON;
                        alarm_pend_n = 1'b0;
                        pair_n       = '0;
                        resume_n     = 1'b0;
                    end else if (state == ST_CHIME_ON) begin
                        state_n = ST_CHIME_OFF;
                        flash_n = flash_cnt - 4'd1;
                    end else if (flash_cnt != 4'd0) begin
                        state_n = ST_CHIME_ON;
                    end else if (resume_snz) begin
                        state_n  = ST_SNOOZE;
                        resume_n = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_ALARM_ON, ST_ALARM_OFF: begin
                alarm_pend_n = 1'b0;
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (snooze) begin
                    if (snz_cnt < SW'(MAX_SNOOZE)) begin
                        state_n = ST_SNOOZE;
                        scnt_n  = snz_cnt + SW'(1);
                        pair_n  = '0;
                        ticks_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (tick) begin
                    if (state == ST_ALARM_ON) begin
                        state_n = ST_ALARM_OFF;
                        pair_n  = pair_cnt + PW'(1);
                    end else if (pair_cnt == PW'(ALARM_FLASHES)) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_ALARM_ON;
                    end
                end
            end
            ST_SNOOZE: begin
                alarm_pend_n = 1'b0;
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    // the tick that starts a chime is not counted as snooze time
                    if (chime_pend) begin
                        state_n      = ST_CHIME_ON;
                        chime_pend_n = 1'b0;
                        flash_n      = flash_count(hour_bin);
                        resume_n     = 1'b1;
                    end else if (snz_ticks == TW'(SNOOZE_TICKS - 1)) begin
                        state_n = ST_ALARM_ON;
                        ticks_n = '0;
                        pair_n  = '0;
                    end else begin
                        ticks_n = snz_ticks + TW'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (state_n == ST_IDLE) begin
            scnt_n   = '0;
            resume_n = 1'b0;
        end
        // a new hit wins over a same-cycle consumption
        if (chime_rise) chime_pend_n = 1'b1;
        if (alarm_rise) alarm_pend_n = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            flash_cnt   <= '0;
            pair_cnt    <= '0;
            snz_ticks   <= '0;
            snz_cnt     <= '0;
            resume_snz  <= 1'b0;
            chime_pend  <= 1'b0;
            alarm_pend  <= 1'b0;
            chime_hit_q <= 1'b0;
            alarm_hit_q <= 1'b0;
            light       <= 1'b0;
            busy        <= 1'b0;
            src         <= SRC_NONE;
        end else begin
            state       <= state_n;
            flash_cnt   <= flash_n;
            pair_cnt    <= pair_n;
            snz_ticks   <= ticks_n;
            snz_cnt     <= scnt_n;
            resume_snz  <= resume_n;
            chime_pend  <= chime_pend_n;
            alarm_pend  <= alarm_pend_n;
            chime_hit_q <= chime_hit;
            alarm_hit_q <= alarm_hit;
            light       <= (state_n == ST_CHIME_ON) || (state_n == ST_ALARM_ON);
            busy        <= (state_n != ST_IDLE);
            src         <= src_of(state_n);
        end
    end

endmodule

// File: tb/tb_chime_scheduler.sv
// Testbench for chime_scheduler. Expected values come from the hour/alarm
// rules computed arithmetically (12-hour dial count, pair/tick totals).
// Honours CHIME_QUIET_EN in its expectations.
module tb_chime_scheduler;

    localparam int ALARM_FLASHES = 60;
    localparam int SNOOZE_TICKS  = 600;
    localparam int MAX_SNOOZE    = 3;
    localparam int TICK_DIV      = 4;
    localparam logic [1:0] S_NONE = 2'd0, S_CHIME = 2'd1, S_ALARM = 2'd2, S_SNOOZE = 2'd3;

    logic       clk = 1'b0;
    logic       rst, tick, alarm_en, snooze, stop;
    logic [7:0] hour, minute, second, alarm_hour, alarm_min;
    logic       light, busy;
    logic [1:0] src;

    int tests_run  = 0;
    int failed     = 0;
    int tick_total = 0;

    chime_scheduler #(
        .ALARM_FLASHES (ALARM_FLASHES),
        .SNOOZE_TICKS  (SNOOZE_TICKS),
        .MAX_SNOOZE    (MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_en   (alarm_en),
        .snooze     (snooze),
        .stop       (stop),
        .light      (light),
        .busy       (busy),
        .src        (src)
    );

    initial forever #5 clk = ~clk;

    // tick every TICK_DIV cycles; tick_total counts ticks the DUT has consumed
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk); tick = 1'b1;
            @(posedge clk); tick_total = tick_total + 1;
            @(negedge clk); tick = 1'b0;
            repeat (TICK_DIV - 2) @(negedge clk);
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // reference: pulses expected for a chime at hour h (binary 0-23)
    function automatic int exp_pulses(input int h);
`ifdef CHIME_QUIET_EN
        if (h >= 22 || h < 7) return 0;
`endif
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    // hold hh:mm:59 briefly, then step to hh:mm:00 (one rising hit)
    task automatic fire(input logic [7:0] h, input logic [7:0] m);
        @(negedge clk);
        hour = h; minute = m; second = 8'h59;
        repeat (2) @(negedge clk);
        second = 8'h00;
    endtask

    task automatic wait_src(input logic [1:0] target, input int limit, output bit ok);
        int cyc = 0;
        while (src !== target && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        ok = (src === target);
    endtask

    task automatic wait_rises(input int n, output bit ok);
        int cnt = 0, cyc = 0;
        logic prev;
        prev = light;
        while (cnt < n && cyc < n * TICK_DIV * 2 + 20) begin
            @(negedge clk);
            cyc++;
            if (light && !prev) cnt++;
            prev = light;
        end
        ok = (cnt == n);
    endtask

    // counts light pulses while src shows the chime; flags wrong widths
    task automatic watch_chime(output int pulses, output int bad_width);
        int cyc = 0, w = 0;
        logic prev;
        pulses = 0; bad_width = 0;
        while (src !== S_CHIME && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        prev = 1'b0; cyc = 0;
        while (src === S_CHIME && cyc < 400) begin
            if (light) begin
                if (!prev) pulses++;
                w++;
            end else if (prev) begin
                if (w != TICK_DIV) bad_width++;
                w = 0;
            end
            prev = light;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (light !== 1'b0) begin failed++; $display("FAIL reset_light: got %b expected 0", light); end
        tests_run++;
        if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (src !== S_NONE) begin failed++; $display("FAIL reset_src: got %0d expected 0", src); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chime_case(input int h);
        int p, bw, e;
        e = exp_pulses(h);
        fire(to_bcd(h), 8'h00);
        watch_chime(p, bw);
        tests_run++;
        if (p !== e) begin failed++; $display("FAIL chime_pulses h=%0d: got %0d expected %0d", h, p, e); end
        tests_run++;
        if (bw !== 0) begin failed++; $display("FAIL chime_width h=%0d: got %0d bad pulses expected 0", h, bw); end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin failed++; $display("FAIL chime_idle h=%0d: busy got %b expected 0", h, busy); end
    endtask

    task automatic test_chime_fixed;
        chime_case(15);
        chime_case(0);
        chime_case(12);
        chime_case(23);
    endtask

    task automatic test_chime_random;
        for (int i = 0; i < 6; i++) chime_case(int'($urandom_range(0, 23)));
    endtask

    task automatic test_alarm_basic;
        int pairs = 0, bad = 0, cyc = 0;
        bit ok;
        logic prev;
        alarm_hour = 8'h07; alarm_min = 8'h30; alarm_en = 1'b1;
        fire(8'h07, 8'h30);
        wait_src(S_ALARM, 40, ok);
        tests_run++;
        if (!ok) begin failed++; $display("FAIL alarm_start: src got %0d expected 2", src); end
        prev = 1'b0;
        while (busy && cyc < ALARM_FLASHES * 2 * TICK_DIV + 100) begin
            if (src !== S_ALARM) bad++;
            if (light && !prev) pairs++;
            prev = light;
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (pairs !== ALARM_FLASHES) begin failed++; $display("FAIL alarm_pairs: got %0d expected %0d", pairs, ALARM_FLASHES); end
        tests_run++;
        if (bad !== 0 || busy !== 1'b0 || light !== 1'b0) begin
            failed++; $display("FAIL alarm_autostop: bad_src=%0d busy=%b light=%b expected 0/0/0", bad, busy, light);
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_snooze;
        int t0;
        bit ok;
        alarm_hour = 8'h07; alarm_min = 8'h45; alarm_en = 1'b1;
        fire(8'h07, 8'h45);
        wait_src(S_ALARM, 40, ok);
        tests_run++;
        if (!ok) begin failed++; $display("FAIL snooze_alarm_start: src got %0d expected 2", src); end
        for (int s = 0; s <= MAX_SNOOZE; s++) begin
            wait_rises(int'($urandom_range(2, 6)), ok);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            snooze = 1'b1;
            @(negedge clk);
            snooze = 1'b0;
            if (s < MAX_SNOOZE) begin
                tests_run++;
                if (src !== S_SNOOZE || light !== 1'b0) begin
                    failed++; $display("FAIL snooze_enter %0d: src=%0d light=%b expected 3/0", s, src, light);
                end
                t0 = tick_total;
                wait_src(S_ALARM, (SNOOZE_TICKS + 4) * TICK_DIV, ok);
                tests_run++;
                if (!ok || (tick_total - t0) != SNOOZE_TICKS) begin
                    failed++; $display("FAIL snooze_ticks %0d: got %0d ticks (resumed=%0b) expected %0d", s, tick_total - t0, ok, SNOOZE_TICKS);
                end
                tests_run++;
                if (light !== 1'b1) begin failed++; $display("FAIL snooze_resume_light %0d: got %b expected 1", s, light); end
            end else begin
                tests_run++;
                if (busy !== 1'b0 || src !== S_NONE || light !== 1'b0) begin
                    failed++; $display("FAIL snooze_over_limit: busy=%b src=%0d light=%b expected 0/0/0", busy, src, light);
                end
            end
        end
        alarm_en = 1'b0;
    endtask

    task automatic test_stop_and_ignore;
        int p, bw;
        bit ok;
        alarm_hour = 8'h07; alarm_min = 8'h50; alarm_en = 1'b1;
        fire(8'h07, 8'h50);
        wait_src(S_ALARM, 40, ok);
        wait_rises(3, ok);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || light !== 1'b0 || src !== S_NONE) begin
            failed++; $display("FAIL alarm_stop: busy=%b light=%b src=%0d expected 0/0/0", busy, light, src);
        end
        alarm_en = 1'b0;
        // stop/snooze during a chime must not disturb it
        fire(8'h03, 8'h00);
        wait_src(S_CHIME, 40, ok);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        snooze = 1'b1; @(negedge clk); snooze = 1'b0;
        watch_chime(p, bw);
        // two cycles of the first pulse elapsed before watching started
        tests_run++;
        if (p !== 3) begin failed++; $display("FAIL chime_ignore_pulses: got %0d expected 3", p); end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin failed++; $display("FAIL chime_ignore_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_alarm_chime_same;
        int saw_chime = 0;
        int cyc = 0;
        bit ok;
        alarm_hour = 8'h08; alarm_min = 8'h00; alarm_en = 1'b1;
        fire(8'h08, 8'h00);
        wait_src(S_ALARM, 40, ok);
        tests_run++;
        if (!ok) begin failed++; $display("FAIL both_alarm_wins: src got %0d expected 2", src); end
        repeat (10 * TICK_DIV) begin
            @(negedge clk);
            if (src === S_CHIME) saw_chime++;
        end
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        while (cyc < 20 * TICK_DIV) begin
            @(negedge clk);
            cyc++;
            if (busy !== 1'b0) saw_chime++;
        end
        tests_run++;
        if (saw_chime !== 0) begin failed++; $display("FAIL both_chime_dropped: got %0d chime/busy cycles expected 0", saw_chime); end
        alarm_en = 1'b0;
    endtask

    task automatic test_chime_in_snooze;
        int m, cyc = 0, pulses = 0, snz = 0, last_ticks;
        bit ok;
        logic [1:0] prev_src;
        logic prev_light;
        alarm_hour = 8'h08; alarm_min = 8'h57; alarm_en = 1'b1;
        fire(8'h08, 8'h57);
        wait_src(S_ALARM, 40, ok);
        wait_rises(2, ok);
        snooze = 1'b1; @(negedge clk); snooze = 1'b0;
        tests_run++;
        if (src !== S_SNOOZE) begin failed++; $display("FAIL cis_enter: src got %0d expected 3", src); end
        m = int'($urandom_range(100, 1500));
        prev_src = src; prev_light = light; last_ticks = tick_total;
        while (src !== S_ALARM && cyc < (SNOOZE_TICKS + 40) * TICK_DIV) begin
            @(negedge clk);
            cyc++;
            if (tick_total != last_ticks && prev_src === S_SNOOZE && src !== S_CHIME) snz++;
            if (src === S_CHIME && light && !prev_light) pulses++;
            last_ticks = tick_total; prev_src = src; prev_light = light;
            if (cyc == m)     begin hour = 8'h09; minute = 8'h00; second = 8'h59; end
            if (cyc == m + 2) second = 8'h00;
        end
        tests_run++;
        if (pulses !== exp_pulses(9)) begin failed++; $display("FAIL cis_pulses: got %0d expected %0d", pulses, exp_pulses(9)); end
        tests_run++;
        if (src !== S_ALARM || snz !== SNOOZE_TICKS) begin
            failed++; $display("FAIL cis_snooze_ticks: got %0d ticks src=%0d expected %0d src=2", snz, src, SNOOZE_TICKS);
        end
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        alarm_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int bad = 0;
        fire(8'h05, 8'h00);
        wait_src(S_CHIME, 40, ok);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (light !== 1'b0 || busy !== 1'b0 || src !== S_NONE) begin
            failed++; $display("FAIL reset_async: light=%b busy=%b src=%0d expected 0/0/0", light, busy, src);
        end
        minute = 8'h59; second = 8'h59;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10 * TICK_DIV) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin failed++; $display("FAIL reset_pending_lost: got %0d busy cycles expected 0", bad); end
    endtask

    initial begin
        rst = 1'b1; alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
        hour = 8'h01; minute = 8'h59; second = 8'h59;
        alarm_hour = 8'h00; alarm_min = 8'h00;
        test_reset;
        test_chime_fixed;
        test_chime_random;
        test_alarm_basic;
        test_snooze;
        test_stop_and_ignore;
        test_alarm_chime_same;
        test_chime_in_snooze;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
